req_rr_arbiter: RTL and testbench

//  Round-robin scheduler sharing one downstream execution unit among NUM_PORTS input FIFOs (inp_fifo instances).

---
 rtl/req_rr_arbiter_pkg.sv | 21 ++
 rtl/rr_pick.sv | 33 +++
 rtl/req_rr_arbiter.sv | 109 ++++++++++
 tb/tb_req_rr_arbiter.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/req_rr_arbiter_pkg.sv
// Shared types for the round-robin request arbiter.
//   req_pkt_type : FIFO head / issue packet; .req marks a valid head
//   arb_state_t  : arbiter FSM states
//   DEF_NUM_PORTS: default number of requesting FIFOs
package req_rr_arbiter_pkg;

  localparam int DEF_NUM_PORTS = 4;

  typedef struct packed {
    logic        req;
    logic [3:0]  op;
    logic [15:0] data;
  } req_pkt_type;

  typedef enum logic [1:0] {
    IDLE,
    POP,
    ISSUE
  } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick.
//   eligible   in  : one bit per port, 1 = port has a valid head
//   last_grant in  : most recently granted port; search starts one above it
//   grant_vld  out : some port is eligible
//   grant_idx  out : first eligible port at last_grant+1, +2, ... mod NUM_PORTS
module rr_pick #(
  parameter int NUM_PORTS = 4,
  parameter int PORT_W    = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] eligible,
  input  logic [PORT_W-1:0]    last_grant,
  output logic                 grant_vld,
  output logic [PORT_W-1:0]    grant_idx
);

  logic [PORT_W-1:0] idx;

  // Walk the ring starting just past the last winner; k == NUM_PORTS lands
  // back on last_grant itself so a lone requester keeps winning.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    idx       = '0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      idx = PORT_W'((int'(last_grant) + k) % NUM_PORTS);
      if (!grant_vld && eligible[idx]) begin
        grant_vld = 1'b1;
        grant_idx = idx;
      end
    end
  end

endmodule

// File: rtl/req_rr_arbiter.sv
// Round-robin scheduler sharing one execution unit among NUM_PORTS FIFOs.
//   clk, rst_b   : clock, synchronous active-low reset
//   head_req     : FIFO head packets, valid when .req == 1
//   fifo_read    : registered one-hot pop pulse to the granted FIFO
//   issue_req    : registered packet to the execution unit
//   issue_port   : source port of issue_req
//   issue_valid  : issue_req valid; held until issue_ready
//   issue_ready  : execution unit accepts issue_req
//   resp_done    : execution unit completed one request (returns a credit)
//   credits      : free credits
//   err_credit   : sticky, resp_done arrived with all credits free
// Flow per packet: IDLE (grant, latch head) -> POP (FIFO pops) -> ISSUE
// (wait for ready). The POP cycle guarantees the FIFO head has advanced
// before the next IDLE decision, so a FIFO is never popped twice for one head.
module req_rr_arbiter
  import req_rr_arbiter_pkg::*;
#(
  parameter int NUM_PORTS = DEF_NUM_PORTS,
  parameter int CREDITS   = 2,
  parameter int PORT_W    = $clog2(NUM_PORTS),
  parameter int CRED_W    = $clog2(CREDITS + 1)
) (
  input  logic                          clk,
  input  logic                          rst_b,
  input  req_pkt_type [NUM_PORTS-1:0]   head_req,
  output logic [NUM_PORTS-1:0]          fifo_read,
  output req_pkt_type                   issue_req,
  output logic [PORT_W-1:0]             issue_port,
  output logic                          issue_valid,
  input  logic                          issue_ready,
  input  logic                          resp_done,
  output logic [CRED_W-1:0]             credits,
  output logic                          err_credit
);

  arb_state_t           state;
  logic [PORT_W-1:0]    last_grant;
  logic [NUM_PORTS-1:0] eligible;
  logic                 grant_vld;
  logic [PORT_W-1:0]    grant_idx;
  logic                 hs;

  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_PORTS; i++) eligible[i] = head_req[i].req;
  end

  assign hs = issue_valid && issue_ready;

  rr_pick #(
    .NUM_PORTS (NUM_PORTS),
    .PORT_W    (PORT_W)
  ) u_pick (
    .eligible   (eligible),
    .last_grant (last_grant),
    .grant_vld  (grant_vld),
    .grant_idx  (grant_idx)
  );

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state       <= IDLE;
      last_grant  <= PORT_W'(NUM_PORTS - 1);
      fifo_read   <= '0;
      issue_req   <= '0;
      issue_port  <= '0;
      issue_valid <= 1'b0;
      credits     <= CRED_W'(CREDITS);
      err_credit  <= 1'b0;
    end else begin
      // A handshake and a response in the same cycle cancel out. A response
      // with every credit already free is a protocol error from downstream.
      unique case ({hs, resp_done})
        2'b10:   credits <= credits - CRED_W'(1);
        2'b01: begin
          if (credits == CRED_W'(CREDITS)) err_credit <= 1'b1;
          else                             credits    <= credits + CRED_W'(1);
        end
        default: ;
      endcase

      unique case (state)
        IDLE: begin
          if (grant_vld && credits != '0) begin
            issue_req  <= head_req[grant_idx];
            issue_port <= grant_idx;
            last_grant <= grant_idx;
            fifo_read  <= NUM_PORTS'(1) << grant_idx;
            state      <= POP;
          end
        end
        POP: begin
          fifo_read   <= '0;
          issue_valid <= 1'b1;
          state       <= ISSUE;
        end
        ISSUE: begin
          if (issue_ready) begin
            issue_valid <= 1'b0;
            issue_req   <= '0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_req_rr_arbiter.sv
module tb_req_rr_arbiter;
  import req_rr_arbiter_pkg::*;

  localparam int NP = 4;
  localparam int CR = 2;
  localparam int PW = 2;
  localparam int CW = 2;

  logic                 clk = 1'b0;
  logic                 rst_b;
  req_pkt_type [NP-1:0] head_req;
  logic [NP-1:0]        fifo_read;
  req_pkt_type          issue_req;
  logic [PW-1:0]        issue_port;
  logic                 issue_valid;
  logic                 issue_ready;
  logic                 resp_done;
  logic [CW-1:0]        credits;
  logic                 err_credit;

  always #5 clk = ~clk;

  req_rr_arbiter #(.NUM_PORTS(NP), .CREDITS(CR)) dut (
    .clk         (clk),
    .rst_b       (rst_b),
    .head_req    (head_req),
    .fifo_read   (fifo_read),
    .issue_req   (issue_req),
    .issue_port  (issue_port),
    .issue_valid (issue_valid),
    .issue_ready (issue_ready),
    .resp_done   (resp_done),
    .credits     (credits),
    .err_credit  (err_credit)
  );

  // Bench-side FIFOs feeding the heads.
  req_pkt_type q [NP][$];

  int errs = 0;
  int nchk = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Reference model: transaction view of the arbiter.
  //   m_free : arbiter may start a new grant at the next edge
  //   m_stage: 0 none, 1 packet granted (valid next cycle), 2 packet offered
  int          m_last, m_cred, m_stage, m_port;
  bit          m_free, m_err, m_iv;
  req_pkt_type m_pkt;
  logic [NP-1:0] m_fr;
  logic [NP-1:0] fr_obs_last;
  bit          hs_seen;
  bit          auto_resp;
  int          grants[$];

  function automatic req_pkt_type new_pkt();
    req_pkt_type p;
    p.req  = 1'b1;
    p.op   = 4'($urandom);
    p.data = 16'($urandom);
    return p;
  endfunction

  function automatic int rr_next();
    for (int k = 1; k <= NP; k++) begin
      int p;
      p = (m_last + k) % NP;
      if (q[p].size() > 0) return p;
    end
    return -1;
  endfunction

  task automatic drive_heads();
    for (int i = 0; i < NP; i++) begin
      if (q[i].size() > 0) head_req[i] = q[i][0];
      else begin
        head_req[i]     = new_pkt();
        head_req[i].req = 1'b0;
      end
    end
  endtask

  task automatic tick();
    bit rst_p, rdy_p, rsp_p;
    rst_p = rst_b;
    rdy_p = issue_ready;
    rsp_p = resp_done;
    @(posedge clk);
    @(negedge clk);
    hs_seen = 1'b0;
    m_fr    = '0;
    if (!rst_p) begin
      m_last = NP - 1; m_cred = CR; m_stage = 0; m_free = 1'b1;
      m_err = 1'b0; m_iv = 1'b0; m_pkt = '0; m_port = 0;
    end else begin
      int g;
      int c_old;
      c_old   = m_cred;
      hs_seen = m_iv && rdy_p;
      if (hs_seen && !rsp_p) m_cred--;
      else if (rsp_p && !hs_seen) begin
        if (m_cred == CR) m_err = 1'b1;
        else              m_cred++;
      end
      g = rr_next();
      if (m_free && g >= 0 && c_old > 0) begin
        m_fr[g] = 1'b1; m_pkt = q[g][0]; m_port = g; m_last = g;
        m_free = 1'b0; m_stage = 1;
      end else if (m_stage == 1) begin
        m_stage = 2; m_iv = 1'b1;
      end else if (m_stage == 2 && hs_seen) begin
        m_stage = 0; m_iv = 1'b0; m_pkt = '0; m_free = 1'b1;
      end
    end
    // The FIFO pops on the edge during which its read pulse was high.
    for (int i = 0; i < NP; i++)
      if (fr_obs_last[i] && q[i].size() > 0) void'(q[i].pop_front());
    chk("fifo_read",   64'(fifo_read),   64'(m_fr));
    chk("issue_valid", 64'(issue_valid), 64'(m_iv));
    chk("issue_req",   64'(issue_req),   64'(m_pkt));
    chk("issue_port",  64'(issue_port),  64'(m_port));
    chk("credits",     64'(credits),     64'(m_cred));
    chk("err_credit",  64'(err_credit),  64'(m_err));
    for (int i = 0; i < NP; i++) if (fifo_read[i]) grants.push_back(i);
    fr_obs_last = fifo_read;
    if (auto_resp) resp_done = hs_seen;
    drive_heads();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_offer(input string tag);
    for (int i = 0; i < 12 && m_stage != 2; i++) tick();
    chk(tag, 64'(m_stage), 64'd2);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int c0;
    req_pkt_type held_req;
    logic [PW-1:0] held_port;

    rst_b = 1'b0; issue_ready = 1'b0; resp_done = 1'b0; auto_resp = 1'b0;
    fr_obs_last = '0;
    m_last = NP - 1; m_cred = CR; m_stage = 0; m_free = 1'b1;
    m_err = 1'b0; m_iv = 1'b0; m_pkt = '0; m_port = 0;
    for (int i = 0; i < NP; i++) repeat (2) q[i].push_back(new_pkt());
    drive_heads();

    // Reset with every head valid.
    run(2);
    chk("rst_credits", 64'(credits), 64'(CR));
    rst_b = 1'b1;

    // All ports busy: grant order follows the ring starting at port 0.
    issue_ready = 1'b1; auto_resp = 1'b1;
    grants.delete();
    run(30);
    chk("rr_count", 64'(grants.size()), 64'd8);
    for (int k = 0; k < 5; k++)
      chk("rr_order", 64'(grants.size() > k ? grants[k] : -1), 64'(k % NP));

    // Single eligible port, three queued packets.
    grants.delete();
    repeat (3) q[2].push_back(new_pkt());
    drive_heads();
    run(15);
    chk("single_count", 64'(grants.size()), 64'd3);
    for (int k = 0; k < grants.size(); k++) chk("single_port", 64'(grants[k]), 64'd2);

    // Credit exhaustion with no responses.
    auto_resp = 1'b0; resp_done = 1'b0;
    grants.delete();
    repeat (3) begin q[0].push_back(new_pkt()); q[1].push_back(new_pkt()); end
    drive_heads();
    run(15);
    chk("cred_zero", 64'(credits), 64'd0);
    chk("cred_block", 64'(grants.size()), 64'd2);
    resp_done = 1'b1;
    tick();
    resp_done = 1'b0;
    run(10);
    chk("cred_resume", 64'(grants.size()), 64'd3);
    if (grants.size() > 2) chk("cred_resume_port", 64'(grants[2]), 64'd0);

    // Backpressure: packet held stable while issue_ready is low.
    issue_ready = 1'b0;
    resp_done = 1'b1; tick(); tick(); resp_done = 1'b0;
    wait_offer("reach_hold");
    held_req = issue_req; held_port = issue_port;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("hold_req",  64'(issue_req),  64'(m_pkt));
      chk("hold_port", 64'(issue_port), 64'(m_port));
    end
    chk("hold_same_req", 64'(issue_req), 64'(held_req));
    chk("hold_same_port", 64'(issue_port), 64'(held_port));
    c0 = m_cred;
    issue_ready = 1'b1; resp_done = 1'b1;
    tick();
    resp_done = 1'b0;
    chk("hs_and_resp", 64'(credits), 64'(c0));
    chk("hs_and_resp_drop", 64'(issue_valid), 64'd0);

    // Drain, then over-return a credit.
    auto_resp = 1'b1;
    run(30);
    auto_resp = 1'b0; resp_done = 1'b0;
    for (int k = 0; k < 4 && m_cred < CR; k++) begin resp_done = 1'b1; tick(); resp_done = 1'b0; end
    chk("full_before_err", 64'(credits), 64'(CR));
    resp_done = 1'b1; tick(); resp_done = 1'b0;
    chk("err_set", 64'(err_credit), 64'd1);
    run(3);
    chk("err_sticky", 64'(err_credit), 64'd1);

    // Reset while a packet is offered.
    issue_ready = 1'b0;
    q[1].push_back(new_pkt());
    drive_heads();
    wait_offer("reach_rst_issue");
    rst_b = 1'b0;
    tick();
    chk("rst_issue_valid", 64'(issue_valid), 64'd0);
    chk("rst_issue_req", 64'(issue_req), 64'd0);
    chk("rst_err", 64'(err_credit), 64'd0);
    chk("rst_cred", 64'(credits), 64'(CR));
    rst_b = 1'b1;
    tick();

    // Random traffic.
    for (int c = 0; c < 500; c++) begin
      if ($urandom_range(0, 2) == 0) begin
        int p;
        p = $urandom_range(0, NP - 1);
        if (q[p].size() < 4) q[p].push_back(new_pkt());
        drive_heads();
      end
      issue_ready = 1'($urandom_range(0, 1));
      resp_done   = ((CR - m_cred) > 0 && $urandom_range(0, 2) == 0) || ($urandom_range(0, 60) == 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errs, nchk);
    $finish;
  end

endmodule
